// File: rtl/switch_debounce_pulse.sv
// switch_debounce_pulse: synchronise and debounce a push-button into a clean level plus press/release pulses.
// Define AUTO_REPEAT_EN to add auto-repeat press pulses while the button is held.
module switch_debounce_pulse #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release
);
    localparam int DW = $clog2(DEBOUNCE_LIMIT);

    logic          sync1_q, sync2_q;
    logic          switch_q, switch_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          expire, rise, fall, rep_pulse;

    always_comb begin
        expire    = (sync2_q != switch_q) && (cnt_q == DW'(DEBOUNCE_LIMIT - 1));
        rise      = expire & sync2_q;
        fall      = expire & ~sync2_q;
        cnt_d     = (sync2_q == switch_q || expire) ? '0 : cnt_q + 1'b1;
        switch_d  = expire ? sync2_q : switch_q;
        press_d   = rise | rep_pulse;
        release_d = fall;
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = ($clog2(RMAX) < 1) ? 1 : $clog2(RMAX);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    // Release takes priority over a coincident repeat expiry.
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        rep_pulse = 1'b0;
        if (rise) begin
            state_d = DELAY;
            rcnt_d  = '0;
        end else if (fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else if (state_q == DELAY) begin
            rep_pulse = rcnt_q == RW'(REPEAT_DELAY - 1);
            rcnt_d    = rep_pulse ? '0 : rcnt_q + 1'b1;
            state_d   = rep_pulse ? REPEAT : DELAY;
        end else if (state_q == REPEAT) begin
            rep_pulse = rcnt_q == RW'(REPEAT_PERIOD - 1);
            rcnt_d    = rep_pulse ? '0 : rcnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            switch_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= i_Switch;
            sync2_q   <= sync1_q;
            switch_q  <= switch_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_Switch  = switch_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;
endmodule

// File: tb/tb_switch_debounce_pulse.sv
// tb_switch_debounce_pulse: directed checks of debounce latency, glitch rejection, pulses and auto-repeat.
module tb_switch_debounce_pulse;
    logic i_Clk = 1'b0, i_Reset = 1'b1, i_Switch = 1'b0;
    logic o_Switch, o_Press, o_Release;
    int   passed = 0, total = 0, both = 0;
    int   pc, pf, rc, rf;
    logic [63:0] pm, exp_m;

`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    switch_debounce_pulse #(.DEBOUNCE_LIMIT(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Switch(i_Switch),
        .o_Switch(o_Switch), .o_Press(o_Press), .o_Release(o_Release)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Tick n edges, sampling 1 ns after each; record pulse counts, first tick and press positions.
    task automatic run(input int n);
        pc = 0; pf = 0; rc = 0; rf = 0; pm = '0;
        for (int i = 1; i <= n; i++) begin
            @(posedge i_Clk);
            #1;
            if (o_Press) begin
                pc++;
                pm[i] = 1'b1;
                if (pf == 0) pf = i;
            end
            if (o_Release) begin
                rc++;
                if (rf == 0) rf = i;
            end
            if (o_Press && o_Release) both++;
        end
    endtask

    initial begin
        // 1. reset, then switch held through reset
        run(3);
        chk("rst_outputs", {o_Switch, o_Press, o_Release}, 0);
        chk("rst_pulses", pc + rc, 0);
        i_Switch = 1'b1;
        run(3);
        chk("rst_held_outputs", {o_Switch, o_Press, o_Release}, 0);
        chk("rst_held_pulses", pc + rc, 0);
        i_Reset = 1'b0;
        run(12);
        chk("post_rst_press_cnt", pc, 1);
        chk("post_rst_press_tick", pf, 6);
        chk("post_rst_level", o_Switch, 1);
        i_Switch = 1'b0;
        run(12);
        chk("post_rst_release_tick", rf, 6);
        // 2. clean press latency
        i_Switch = 1'b1;
        run(5);
        chk("press_early", {o_Switch, o_Press}, 0);
        run(1);
        chk("press_edge5", {o_Switch, o_Press, o_Release}, 3'b110);
        run(1);
        chk("press_edge6", {o_Switch, o_Press}, 2'b10);
        i_Switch = 1'b0;
        run(12);
        chk("rel2_tick", rf, 6);
        chk("rel2_level", o_Switch, 0);
        // 3. bounce 1,0,1,0 then steady 1
        for (int k = 0; k < 4; k++) begin
            i_Switch = ~k[0];
            run(1);
            chk("bounce_quiet", pc + rc, 0);
        end
        i_Switch = 1'b1;
        run(12);
        chk("bounce_press_cnt", pc, 1);
        chk("bounce_press_tick", pf, 6);
        i_Switch = 1'b0;
        run(12);
        chk("bounce_rel_tick", rf, 6);
        // 4. three-cycle glitch is rejected
        i_Switch = 1'b1;
        run(3);
        chk("glitch_hi", pc + rc, 0);
        i_Switch = 1'b0;
        run(10);
        chk("glitch_pulses", pc + rc, 0);
        chk("glitch_level", o_Switch, 0);
        // 5/6. press, hold 30 cycles, release
        i_Switch = 1'b1;
        run(6);
        chk("hold_press_tick", pf, 6);
        chk("hold_press_cnt", pc, 1);
        run(30);
        exp_m = AUTO ? (64'h1 << 10 | 64'h1 << 15 | 64'h1 << 20 | 64'h1 << 25 | 64'h1 << 30) : 64'h0;
        chk("hold_repeat_mask", pm, exp_m);
        chk("hold_level", o_Switch, 1);
        i_Switch = 1'b0;
        run(6);
        chk("rel5_tick", rf, 6);
        chk("rel5_cnt", rc, 1);
        exp_m = AUTO ? 64'h1 << 5 : 64'h0;
        chk("rel5_press_mask", pm, exp_m);
        chk("rel5_level", o_Switch, 0);
        run(25);
        chk("after_rel_quiet", pc + rc, 0);
        chk("never_both", both, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
